// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty watermarks
// and sticky overflow/underflow flags; FWFT or registered-read output.
module sync_fifo_flags #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    parameter  int AFULL_LVL  = 14,
    parameter  int AEMPTY_LVL = 2,
    parameter  int FWFT       = 1,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wEn,
    input  logic [DATA_WIDTH-1:0] wData,
    output logic                  full,
    output logic                  almostFull,
    input  logic                  rEn,
    output logic [DATA_WIDTH-1:0] rData,
    output logic                  rValid,
    output logic                  empty,
    output logic                  almostEmpty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C   = (ADDR_WIDTH+1)'(AFULL_LVL);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C  = (ADDR_WIDTH+1)'(AEMPTY_LVL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                wr_acc;
    logic                rd_acc;

    // Flags decode only the registered count, so they never depend on wEn/rEn.
    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign almostFull  = (count_q >= AFULL_C);
    assign almostEmpty = (count_q <= AEMPTY_C);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    assign wr_acc = wEn && !full;
    assign rd_acc = rEn && !empty;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (wEn & full);
        underflow_d = underflow_q | (rEn & empty);
        if (wr_acc) begin
            wptr_d = wptr_q + ONE;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + ONE;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wptr_q[ADDR_WIDTH-1:0]] <= wData;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rData  = mem[rptr_q[ADDR_WIDTH-1:0]];
            assign rValid = ~empty;
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
            logic                  rvalid_q, rvalid_d;

            always_comb begin
                rdata_d  = rdata_q;
                rvalid_d = rd_acc;
                if (rd_acc) begin
                    rdata_d = mem[rptr_q[ADDR_WIDTH-1:0]];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign rData  = rdata_q;
            assign rValid = rvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench: an FWFT DEPTH=4 instance driven from a vector table
// plus wrap-around rounds, and a registered-read DEPTH=8 instance.
module tb_sync_fifo_flags;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // FWFT instance: DEPTH=4, AFULL_LVL=3, AEMPTY_LVL=1
    logic       a_rst = 1'b0, a_wEn = 1'b0, a_rEn = 1'b0;
    logic [7:0] a_wData = '0, a_rData;
    logic       a_full, a_almostFull, a_rValid, a_empty, a_almostEmpty, a_overflow, a_underflow;
    logic [2:0] a_count;

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(4), .AFULL_LVL(3), .AEMPTY_LVL(1), .FWFT(1)) u_dut_a (
        .clk(clk), .rst(a_rst), .wEn(a_wEn), .wData(a_wData), .full(a_full),
        .almostFull(a_almostFull), .rEn(a_rEn), .rData(a_rData), .rValid(a_rValid),
        .empty(a_empty), .almostEmpty(a_almostEmpty), .count(a_count),
        .overflow(a_overflow), .underflow(a_underflow)
    );

    // Registered-read instance: DEPTH=8, AFULL_LVL=6, AEMPTY_LVL=2
    logic       b_rst = 1'b0, b_wEn = 1'b0, b_rEn = 1'b0;
    logic [7:0] b_wData = '0, b_rData;
    logic       b_full, b_almostFull, b_rValid, b_empty, b_almostEmpty, b_overflow, b_underflow;
    logic [3:0] b_count;

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(8), .AFULL_LVL(6), .AEMPTY_LVL(2), .FWFT(0)) u_dut_b (
        .clk(clk), .rst(b_rst), .wEn(b_wEn), .wData(b_wData), .full(b_full),
        .almostFull(b_almostFull), .rEn(b_rEn), .rData(b_rData), .rValid(b_rValid),
        .empty(b_empty), .almostEmpty(b_almostEmpty), .count(b_count),
        .overflow(b_overflow), .underflow(b_underflow)
    );

    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle on the FWFT instance; the shown head word is compared
    // against the scoreboard whenever a read is accepted.
    task automatic step_a(input logic r, input logic w, input logic [7:0] d, input logic rd);
        bit wacc, racc;
        a_rst = r; a_wEn = w; a_wData = d; a_rEn = rd;
        wacc = !r && w && (sb_a.size() < 4);
        racc = !r && rd && (sb_a.size() > 0);
        if (racc) begin
            check("a_pop_data", a_rData, sb_a[0]);
            $display("A pop  data=0x%0h", a_rData);
            void'(sb_a.pop_front());
        end
        if (wacc) sb_a.push_back(d);
        if (r) sb_a.delete();
        @(posedge clk);
        #1;
        a_rst = 1'b0; a_wEn = 1'b0; a_rEn = 1'b0;
    endtask

    // Drive one cycle on the registered-read instance; data is checked when
    // rValid is expected in the following cycle.
    task automatic step_b(input logic r, input logic w, input logic [7:0] d, input logic rd);
        bit wacc, racc;
        logic [7:0] exp_d;
        b_rst = r; b_wEn = w; b_wData = d; b_rEn = rd;
        wacc = !r && w && (sb_b.size() < 8);
        racc = !r && rd && (sb_b.size() > 0);
        exp_d = '0;
        if (racc) begin
            exp_d = sb_b[0];
            void'(sb_b.pop_front());
        end
        if (wacc) sb_b.push_back(d);
        if (r) sb_b.delete();
        @(posedge clk);
        #1;
        b_rst = 1'b0; b_wEn = 1'b0; b_rEn = 1'b0;
        check("b_rvalid", b_rValid, racc);
        if (racc) check("b_rdata", b_rData, exp_d);
        $display("B step rst=%0b wEn=%0b rEn=%0b -> rValid=%0b rData=0x%0h count=%0d",
                 r, w, rd, b_rValid, b_rData, b_count);
    endtask

    typedef struct {
        logic       rst, wen;
        logic [7:0] wd;
        logic       ren;
        logic [2:0] cnt;
        logic       full, empty, af, ae, ovf, unf;
    } vec_t;

    vec_t vecs[15];

    initial begin
        //           rst  wen  wd     ren   cnt   full empty af  ae  ovf unf
        vecs[0]  = '{1'b1,1'b0,8'h00,1'b0, 3'd0, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b1,8'h0A,1'b0, 3'd1, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b1,8'h0B,1'b0, 3'd2, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b1,8'h0C,1'b0, 3'd3, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b1,8'h0D,1'b0, 3'd4, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b1,8'h0E,1'b1, 3'd3, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0};
        vecs[6]  = '{1'b0,1'b0,8'h00,1'b1, 3'd2, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
        vecs[7]  = '{1'b0,1'b0,8'h00,1'b1, 3'd1, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
        vecs[8]  = '{1'b0,1'b0,8'h00,1'b1, 3'd0, 1'b0,1'b1,1'b0,1'b1,1'b1,1'b0};
        vecs[9]  = '{1'b0,1'b0,8'h00,1'b1, 3'd0, 1'b0,1'b1,1'b0,1'b1,1'b1,1'b1};
        vecs[10] = '{1'b0,1'b1,8'h05,1'b1, 3'd1, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
        vecs[11] = '{1'b0,1'b1,8'h06,1'b0, 3'd2, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1};
        vecs[12] = '{1'b0,1'b1,8'h07,1'b0, 3'd3, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b1};
        vecs[13] = '{1'b1,1'b1,8'h08,1'b0, 3'd0, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0};
        vecs[14] = '{1'b0,1'b0,8'h00,1'b0, 3'd0, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0};

        for (int i = 0; i < 15; i++) begin
            step_a(vecs[i].rst, vecs[i].wen, vecs[i].wd, vecs[i].ren);
            check("a_count", a_count, vecs[i].cnt);
            check("a_full", a_full, vecs[i].full);
            check("a_empty", a_empty, vecs[i].empty);
            check("a_almost_full", a_almostFull, vecs[i].af);
            check("a_almost_empty", a_almostEmpty, vecs[i].ae);
            check("a_overflow", a_overflow, vecs[i].ovf);
            check("a_underflow", a_underflow, vecs[i].unf);
            check("a_rvalid", a_rValid, !vecs[i].empty);
            if (!vecs[i].empty) check("a_head_data", a_rData, sb_a[0]);
            $display("A vec %0d rst=%0b wEn=%0b wData=0x%0h rEn=%0b -> count=%0d rData=0x%0h ovf=%0b unf=%0b",
                     i, vecs[i].rst, vecs[i].wen, vecs[i].wd, vecs[i].ren, a_count, a_rData,
                     a_overflow, a_underflow);
        end

        // Pointer wrap: 10 rounds of 3 writes then 3 reads.
        for (int rnd = 0; rnd < 10; rnd++) begin
            for (int k = 0; k < 3; k++) begin
                step_a(1'b0, 1'b1, 8'(rnd * 3 + k + 8'h40), 1'b0);
                check("wrap_count_wr", a_count, 3'(k + 1));
                check("wrap_full", a_full, 1'b0);
                check("wrap_empty_wr", a_empty, 1'b0);
            end
            for (int k = 0; k < 3; k++) begin
                step_a(1'b0, 1'b0, 8'h00, 1'b1);
                check("wrap_count_rd", a_count, 3'(2 - k));
            end
            check("wrap_empty", a_empty, 1'b1);
            check("wrap_sb_empty", sb_a.size(), 0);
        end

        // Registered-read instance.
        step_b(1'b1, 1'b0, 8'h00, 1'b0);
        check("b_reset_rdata", b_rData, 8'h00);
        check("b_reset_empty", b_empty, 1'b1);
        check("b_reset_count", b_count, 4'd0);
        step_b(1'b0, 1'b1, 8'h11, 1'b0);
        step_b(1'b0, 1'b1, 8'h22, 1'b0);
        check("b_count2", b_count, 4'd2);
        check("b_rvalid_idle", b_rValid, 1'b0);
        step_b(1'b0, 1'b0, 8'h00, 1'b1);
        check("b_first_read", b_rData, 8'h11);
        step_b(1'b0, 1'b0, 8'h00, 1'b1);
        check("b_second_read", b_rData, 8'h22);
        step_b(1'b0, 1'b0, 8'h00, 1'b0);
        check("b_hold_data", b_rData, 8'h22);
        step_b(1'b0, 1'b0, 8'h00, 1'b1);
        check("b_rejected_rvalid", b_rValid, 1'b0);
        check("b_underflow", b_underflow, 1'b1);
        check("b_hold_after_reject", b_rData, 8'h22);
        check("b_overflow", b_overflow, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Single-clock, parametrised FIFO with occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. A build-time mode selects first-word-fall-through (FWFT) or registered-read output. It is used wherever producer and consumer share one clock, and provides flow-control watermarks for upstream throttling.

Parameters:
DATA_WIDTH, 32, data word width in bits
DEPTH, 16, number of entries; must be a power of 2 and at least 2
AFULL_LVL, 14, almostFull asserts when count >= AFULL_LVL; legal range 1..DEPTH
AEMPTY_LVL, 2, almostEmpty asserts when count <= AEMPTY_LVL; legal range 0..DEPTH-1
FWFT, 1, 1 = head word visible on rData while not empty; 0 = registered read, data one cycle after accepted rEn
(derived) ADDR_WIDTH = $clog2(DEPTH)

Ports:
clk  input  1  single clock; all logic on posedge
rst  input  1  synchronous, active-high reset
wEn  input  1  write request
wData  input  DATA_WIDTH  write data
full  output  1  count == DEPTH
almostFull  output  1  count >= AFULL_LVL
rEn  input  1  read request
rData  output  DATA_WIDTH  read data
rValid  output  1  FWFT=1: equals ~empty; FWFT=0: one-cycle pulse marking rData valid
empty  output  1  count == 0
almostEmpty  output  1  count <= AEMPTY_LVL
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky; set by wEn while full
underflow  output  1  sticky; set by rEn while empty

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: wPtr=rPtr=0, count=0, empty=1, full=0, almostEmpty=1, almostFull=0, overflow=0, underflow=0, rValid=0, rData=0 in FWFT=0. Memory contents are not reset.
- Reset mid-operation discards all stored words. Reset wins over any same-cycle wEn/rEn.
- Pointers are ADDR_WIDTH+1 bits wide; the low ADDR_WIDTH bits address memory. Pointers wrap naturally modulo 2*DEPTH.
- Write is accepted iff wEn && !full: mem[wPtr] <= wData and wPtr increments.
- Read is accepted iff rEn && !empty: rPtr increments.
- full and empty are evaluated on the pre-edge count.
- count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous accepted read and write when neither full nor empty: count unchanged.
- Write while full with rEn: the write is rejected and overflow is set; the read is accepted; count becomes DEPTH-1 next cycle.
- Read while empty with wEn: the read is rejected and underflow is set; the write is accepted; count becomes 1 next cycle.
- Flags are combinational decodes of the registered count only. They have no path from wEn/rEn in the same cycle.
- FWFT=1:
  - rData = mem[rPtr] combinationally.
  - A word written at edge N is visible, with empty=0, after edge N.
  - rEn pops the word currently shown.
- FWFT=0:
  - An accepted read at edge N loads rData with mem[rPtr] and pulses rValid=1 during cycle N+1.
  - rData holds its value when no read is accepted.
  - A rejected read leaves rValid=0.
- overflow and underflow stay set until rst. They do not affect data.
- No read-during-write bypass is needed. With count==0 the read is rejected regardless.

Test Plan:
1. DEPTH=4, FWFT=1: reset, then write 0xA,0xB,0xC,0xD on consecutive cycles -> count 1,2,3,4; full=1 after the 4th edge; almostFull per AFULL_LVL=3 asserts at count=3; rData=0xA from the cycle after the first write.
2. Full FIFO, wEn=1 with wData=0xE and rEn=1 -> 0xA popped, 0xE dropped, count=3, overflow=1; subsequent reads return 0xB,0xC,0xD, then empty=1.
3. Empty FIFO, rEn=1 alone -> underflow=1, count stays 0, rValid=0. Then rEn=1 and wEn=1 with 0x5 -> count=1, rData=0x5 next cycle.
4. FWFT=0, DEPTH=8: write 0x11,0x22, then rEn on two cycles -> rValid pulses in the two following cycles with rData 0x11 then 0x22; rData holds 0x22 afterwards.
5. Wrap-around, DEPTH=4: 10 rounds of 3 writes then 3 reads with an incrementing pattern -> data order preserved, no false full/empty across pointer wrap, count never exceeds 4.
6. With count=3 and overflow=1, assert rst for one cycle together with wEn -> the next cycle shows count=0, empty=1, overflow=0, underflow=0, and the write is ignored.
